// File: rtl/csr_commit_pkg.sv
// -----------------------------------------------------------------------------
// csr_commit_pkg
// Shared pipeline definitions for the CSR commit stage:
//   - csr_req_t     : CSR side-band carried by a retiring instruction
//   - CSR_*         : machine-mode CSR addresses implemented by csr_commit
//   - MSTATUS_*     : mstatus field positions and the writable-bit mask
//   - state_e       : commit FSM state encoding
//   - csr_writable(): true for addresses that accept software writes
// -----------------------------------------------------------------------------
package csr_commit_pkg;

   typedef struct packed {
      logic        wvalid;
      logic [11:0] wa;
      logic [63:0] wd;
      logic        is_mret;
      logic        error;
      logic [3:0]  code;
   } csr_req_t;

   localparam logic [11:0] CSR_SATP     = 12'h180;
   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;

   // Only MIE, MPIE and MPP[1:0] exist; every other mstatus bit is hardwired 0.
   localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;

   localparam logic [1:0] MODE_U = 2'b00;
   localparam logic [1:0] MODE_M = 2'b11;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_REDIRECT = 1'b1
   } state_e;

   function automatic logic csr_writable(input logic [11:0] addr);
      case (addr)
         CSR_SATP, CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
         CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE: csr_writable = 1'b1;
         default:                                              csr_writable = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/csr_commit.sv
// -----------------------------------------------------------------------------
// csr_commit
// Machine-mode CSR file and trap/mret sequencer at the commit stage.
// Ports:
//   clk          : clock, all state on rising edge
//   resetn       : asynchronous active-low reset
//   commit_valid : retiring instruction present
//   commit_pc    : PC of the retiring instruction
//   commit_csr   : CSR side-band (write, mret, trap request)
//   stall        : pipeline stalled, no commit accepted
//   ra           : CSR read address from decode
//   rd           : combinational CSR read data (with write bypass)
//   mode         : current privilege (00 U, 11 M)
//   redirect     : one-cycle flush/redirect pulse
//   redirect_pc  : redirect target, valid while redirect=1
// -----------------------------------------------------------------------------
module csr_commit
   import csr_commit_pkg::*;
#(
   parameter logic [63:0] HART_ID     = 64'd0,
   parameter logic [63:0] MTVEC_RESET = 64'h0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        commit_valid,
   input  logic [63:0] commit_pc,
   input  csr_req_t    commit_csr,
   input  logic        stall,
   input  logic [11:0] ra,
   output logic [63:0] rd,
   output logic [1:0]  mode,
   output logic        redirect,
   output logic [63:0] redirect_pc
);

   state_e      state_q, state_d;
   logic [63:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mip_q, mip_d;
   logic [63:0] mie_q, mie_d, mscratch_q, mscratch_d, mcause_q, mcause_d;
   logic [63:0] mtval_q, mtval_d, mepc_q, mepc_d, mcycle_q, mcycle_d;
   logic [63:0] satp_q, satp_d, redirect_pc_q, redirect_pc_d;
   logic [1:0]  mode_q, mode_d;

   logic accept, do_trap, do_mret, do_write;

   // Priority error > mret > write: lower-priority actions are simply masked.
   assign accept   = commit_valid & ~stall & (state_q == ST_RUN);
   assign do_trap  = accept & commit_csr.error;
   assign do_mret  = accept & ~commit_csr.error & commit_csr.is_mret;
   assign do_write = accept & ~commit_csr.error & ~commit_csr.is_mret & commit_csr.wvalid;

   // FSM: REDIRECT lasts exactly one cycle regardless of stall.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:      if (do_trap | do_mret) state_d = ST_REDIRECT;
         ST_REDIRECT: state_d = ST_RUN;
         default:     state_d = ST_RUN;
      endcase
   end

   always_comb begin
      mstatus_d     = mstatus_q;
      mtvec_d       = mtvec_q;
      mip_d         = mip_q;
      mie_d         = mie_q;
      mscratch_d    = mscratch_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      mepc_d        = mepc_q;
      satp_d        = satp_q;
      mode_d        = mode_q;
      redirect_pc_d = redirect_pc_q;
      mcycle_d      = mcycle_q + 64'd1;

      if (do_write) begin
         case (commit_csr.wa)
            CSR_MSTATUS:  mstatus_d  = commit_csr.wd & MSTATUS_WMASK;
            CSR_MTVEC:    mtvec_d    = commit_csr.wd;
            CSR_MIP:      mip_d      = commit_csr.wd;
            CSR_MIE:      mie_d      = commit_csr.wd;
            CSR_MSCRATCH: mscratch_d = commit_csr.wd;
            CSR_MCAUSE:   mcause_d   = commit_csr.wd;
            CSR_MTVAL:    mtval_d    = commit_csr.wd;
            CSR_MEPC:     mepc_d     = commit_csr.wd;
            CSR_SATP:     satp_d     = commit_csr.wd;
            CSR_MCYCLE:   mcycle_d   = commit_csr.wd;
            default:      ;
         endcase
      end

      if (do_trap) begin
         mepc_d                             = commit_pc;
         mcause_d                           = {60'b0, commit_csr.code};
         mtval_d                            = 64'd0;
         mstatus_d[MSTATUS_MPIE]            = mstatus_q[MSTATUS_MIE];
         mstatus_d[MSTATUS_MIE]             = 1'b0;
         mstatus_d[MSTATUS_MPP_LO +: 2]     = mode_q;
         mode_d                             = MODE_M;
         redirect_pc_d                      = {mtvec_q[63:2], 2'b00};
      end

      if (do_mret) begin
         mode_d                             = mstatus_q[MSTATUS_MPP_LO +: 2];
         mstatus_d[MSTATUS_MIE]             = mstatus_q[MSTATUS_MPIE];
         mstatus_d[MSTATUS_MPIE]            = 1'b1;
         mstatus_d[MSTATUS_MPP_LO +: 2]     = MODE_U;
         redirect_pc_d                      = mepc_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_RUN;
         mstatus_q     <= 64'd0;
         mtvec_q       <= MTVEC_RESET;
         mip_q         <= 64'd0;
         mie_q         <= 64'd0;
         mscratch_q    <= 64'd0;
         mcause_q      <= 64'd0;
         mtval_q       <= 64'd0;
         mepc_q        <= 64'd0;
         mcycle_q      <= 64'd0;
         satp_q        <= 64'd0;
         mode_q        <= MODE_M;
         redirect_pc_q <= 64'd0;
      end else begin
         state_q       <= state_d;
         mstatus_q     <= mstatus_d;
         mtvec_q       <= mtvec_d;
         mip_q         <= mip_d;
         mie_q         <= mie_d;
         mscratch_q    <= mscratch_d;
         mcause_q      <= mcause_d;
         mtval_q       <= mtval_d;
         mepc_q        <= mepc_d;
         mcycle_q      <= mcycle_d;
         satp_q        <= satp_d;
         mode_q        <= mode_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   // Read port; a same-cycle accepted write to ra is forwarded so decode sees
   // the value the register will hold after this edge.
   always_comb begin
      case (ra)
         CSR_MSTATUS:  rd = mstatus_q;
         CSR_MTVEC:    rd = mtvec_q;
         CSR_MIP:      rd = mip_q;
         CSR_MIE:      rd = mie_q;
         CSR_MSCRATCH: rd = mscratch_q;
         CSR_MCAUSE:   rd = mcause_q;
         CSR_MTVAL:    rd = mtval_q;
         CSR_MEPC:     rd = mepc_q;
         CSR_SATP:     rd = satp_q;
         CSR_MCYCLE:   rd = mcycle_q;
         CSR_MHARTID:  rd = HART_ID;
         default:      rd = 64'd0;
      endcase
      if (do_write && (commit_csr.wa == ra) && csr_writable(ra)) begin
         rd = (ra == CSR_MSTATUS) ? (commit_csr.wd & MSTATUS_WMASK) : commit_csr.wd;
      end
   end

   assign mode        = mode_q;
   assign redirect    = (state_q == ST_REDIRECT);
   assign redirect_pc = redirect_pc_q;

endmodule
